// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// UART transmit engine behind the CPU TX valid/ready handshake. It accepts one
// byte per handshake and shifts it onto the TX pin as an 8N1 frame: a start
// bit, 8 data bits LSB first, then a stop bit. tx_ready (data_in_ready) is
// polled by software through bit 0 of the UART control register.
//
// Optional feature (compile-time macro): UART_TX_PARITY_EN
//   defined     : an even-parity symbol is inserted between the data bits and
//                 the stop bit (8E1, 11 symbols per frame).
//   not defined : plain 8N1, 10 symbols per frame, no parity logic at all.
//
// Parameters
//   CLOCK_FREQ    core clock frequency in Hz
//   BAUD_RATE     line rate in bits/s
//   SYMBOL_CYCLES CLOCK_FREQ / BAUD_RATE (integer division), must be >= 2
//
// Ports
//   clk            in   1  core clock, rising-edge active
//   rst            in   1  synchronous, active-high reset
//   data_in        in   8  byte to transmit
//   data_in_valid  in   1  producer asserts while data_in is valid
//   data_in_ready  out  1  high while idle (a byte can be accepted)
//   serial_out     out  1  TX line, idle-high, registered
//   busy_out       out  1  high while a frame is on the line
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_tx_serializer #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out,
    output logic       busy_out
);

    localparam int SYMBOL_CYCLES = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W         = $clog2(SYMBOL_CYCLES);

    localparam logic [CNT_W-1:0] CYC_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CYC_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(SYMBOL_CYCLES - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Even parity: XOR of all data bits, so the total count of ones incl.
    // the parity bit is even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } state_t;
`endif

    state_t           state_r;
    logic [CNT_W-1:0] cyc_cnt_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       shift_r;
`ifdef UART_TX_PARITY_EN
    logic             parity_r;
`endif
    logic             sym_end_s;

    // Last cycle of the current symbol; every state transition happens here.
    assign sym_end_s = (cyc_cnt_r == CYC_LAST);

    // Handshake status decoded straight from the state register.
    assign data_in_ready = (state_r == IDLE);
    assign busy_out      = (state_r != IDLE);

    // Frame sequencer: state, symbol timing, shift register and the TX line.
    // serial_out is loaded one edge ahead of the symbol it represents, so the
    // line changes exactly on symbol boundaries and never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cyc_cnt_r  <= CYC_ZERO;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            serial_out <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    serial_out <= 1'b1;
                    cyc_cnt_r  <= CYC_ZERO;
                    bit_cnt_r  <= 3'd0;
                    if (data_in_valid && data_in_ready) begin
                        shift_r    <= data_in;
`ifdef UART_TX_PARITY_EN
                        parity_r   <= even_parity(data_in);
`endif
                        serial_out <= 1'b0;
                        state_r    <= START;
                    end
                end

                START: begin
                    if (sym_end_s) begin
                        cyc_cnt_r  <= CYC_ZERO;
                        serial_out <= shift_r[0];
                        state_r    <= DATA;
                    end else begin
                        cyc_cnt_r  <= cyc_cnt_r + CYC_ONE;
                    end
                end

                DATA: begin
                    if (sym_end_s) begin
                        cyc_cnt_r <= CYC_ZERO;
                        if (bit_cnt_r == 3'd7) begin
                            bit_cnt_r  <= 3'd0;
`ifdef UART_TX_PARITY_EN
                            serial_out <= parity_r;
                            state_r    <= PARITY;
`else
                            serial_out <= 1'b1;
                            state_r    <= STOP;
`endif
                        end else begin
                            bit_cnt_r  <= bit_cnt_r + 3'd1;
                            shift_r    <= {1'b0, shift_r[7:1]};
                            // Next bit is shift_r[1] before the shift lands.
                            serial_out <= shift_r[1];
                        end
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + CYC_ONE;
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (sym_end_s) begin
                        cyc_cnt_r  <= CYC_ZERO;
                        serial_out <= 1'b1;
                        state_r    <= STOP;
                    end else begin
                        cyc_cnt_r  <= cyc_cnt_r + CYC_ONE;
                    end
                end
`endif

                STOP: begin
                    serial_out <= 1'b1;
                    if (sym_end_s) begin
                        cyc_cnt_r <= CYC_ZERO;
                        state_r   <= IDLE;
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + CYC_ONE;
                    end
                end

                default: begin
                    state_r    <= IDLE;
                    cyc_cnt_r  <= CYC_ZERO;
                    bit_cnt_r  <= 3'd0;
                    serial_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Directed self-checking bench for uart_tx_serializer with CLOCK_FREQ=1000,
// BAUD_RATE=100 (10 clocks per symbol). Expected frames are hand-written
// constants: bit i of a frame constant is symbol i on the line (bit 0 = start,
// bits 1..8 = data LSB first, bit 9 = stop). Honours UART_TX_PARITY_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_tx_serializer;

    localparam int SYM = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NSYM = 11;
`else
    localparam int NSYM = 10;
`endif
    localparam int FRAME = NSYM * SYM;

    // Hand-computed line patterns {stop, d7..d0, start}.
    localparam logic [9:0] FR_A5 = 10'b1101001010;
    localparam logic [9:0] FR_55 = 10'b1010101010;
    localparam logic [9:0] FR_00 = 10'b1000000000;
    localparam logic [9:0] FR_FF = 10'b1111111110;
    localparam logic [9:0] FR_81 = 10'b1100000010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;
    logic       busy_out;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_serializer #(
        .CLOCK_FREQ (1000),
        .BAUD_RATE  (100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out),
        .busy_out      (busy_out)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_symbol(input logic [9:0] fr, input logic par, input int sym);
`ifdef UART_TX_PARITY_EN
        if (sym < 9)       return fr[sym];
        else if (sym == 9) return par;
        else               return fr[9];
`else
        if (par) return fr[sym];
        else     return fr[sym];
`endif
    endfunction

    // Called in cycle 1 of a frame (just after the handshake edge); returns in
    // cycle FRAME+1. Optionally pulses valid with another byte mid-frame.
    task automatic check_frame_body(input string tag, input logic [9:0] fr, input logic par,
                                    input int pulse_at, input logic [7:0] pulse_byte);
        int low_cnt = 0;
        for (int k = 1; k <= FRAME; k++) begin
            if (k == 1) begin
                check_val($sformatf("%s first_low", tag), serial_out, 0);
                check_val($sformatf("%s busy", tag), busy_out, 1);
            end
            if (!data_in_ready) low_cnt++;
            if (((k - 1) % SYM) == (SYM / 2 - 1)) begin
                check_val($sformatf("%s sym%0d", tag, (k - 1) / SYM), serial_out,
                          exp_symbol(fr, par, (k - 1) / SYM));
            end
            if (pulse_at != 0 && k == pulse_at) begin
                data_in       = pulse_byte;
                data_in_valid = 1'b1;
            end else if (pulse_at != 0 && k == pulse_at + 1) begin
                data_in_valid = 1'b0;
            end
            tick();
        end
        check_val($sformatf("%s ready_low_cycles", tag), low_cnt, FRAME);
    endtask

    // Handshake one byte from idle, check the full frame and the idle after it.
    task automatic send_frame(input string tag, input logic [7:0] b, input logic [9:0] fr,
                              input logic par, input int pulse_at, input logic [7:0] pulse_byte);
        data_in       = b;
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        check_frame_body(tag, fr, par, pulse_at, pulse_byte);
        check_val($sformatf("%s ready_after", tag), data_in_ready, 1);
        check_val($sformatf("%s busy_after", tag), busy_out, 0);
        check_val($sformatf("%s line_after", tag), serial_out, 1);
    endtask

    initial begin
        int bad;

        // Reset held for 3 cycles.
        rst = 1'b1;
        repeat (3) tick();
        check_val("rst serial_out", serial_out, 1);
        check_val("rst ready", data_in_ready, 1);
        check_val("rst busy", busy_out, 0);
        rst = 1'b0;
        tick();

        // Single 0xA5 frame.
        send_frame("a5", 8'hA5, FR_A5, 1'b0, 0, 8'h00);
        tick();

        // Back-to-back 0x00 then 0xFF with valid held high.
        data_in       = 8'h00;
        data_in_valid = 1'b1;
        tick();
        data_in = 8'hFF;
        check_frame_body("b2b_00", FR_00, 1'b0, 0, 8'h00);
        check_val("b2b gap ready", data_in_ready, 1);
        check_val("b2b gap line", serial_out, 1);
        tick();
        data_in_valid = 1'b0;
        check_frame_body("b2b_ff", FR_FF, 1'b0, 0, 8'h00);
        check_val("b2b ready_after", data_in_ready, 1);
        tick();

        // 0x3C pulsed during the DATA phase of a 0x55 frame must be dropped.
        send_frame("55", 8'h55, FR_55, 1'b0, 35, 8'h3C);
        bad = 0;
        repeat (20) begin
            if (serial_out !== 1'b1 || busy_out !== 1'b0) bad++;
            tick();
        end
        check_val("no_3c_frame", bad, 0);

        // Reset at cycle 45 of a 0x00 frame.
        data_in       = 8'h00;
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
        repeat (44) tick();
        check_val("pre_rst line", serial_out, 0);
        rst = 1'b1;
        tick();
        check_val("mid_rst line", serial_out, 1);
        check_val("mid_rst ready", data_in_ready, 1);
        check_val("mid_rst busy", busy_out, 0);
        rst = 1'b0;
        bad = 0;
        repeat (15) begin
            tick();
            if (serial_out !== 1'b1 || busy_out !== 1'b0) bad++;
        end
        check_val("post_rst idle", bad, 0);
        send_frame("81", 8'h81, FR_81, 1'b0, 0, 8'h00);

        // Long idle with valid low.
        data_in_valid = 1'b0;
        bad = 0;
        repeat (200) begin
            tick();
            if (serial_out !== 1'b1 || busy_out !== 1'b0) bad++;
        end
        check_val("idle200", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
